video_timing_gen: RTL and testbench

Generates the raster timing that drives every pixel-producing block (star background, sprites, HUD): signed pixel coordinates, sync pulses, data-enable and per-line and per-frame strobes, all on `pixel_clk`. Coordinates are negative during blanking and 0..HRES-1 / 0..VRES-1 in the visible area. Its outputs are the `hpos`/`vpos`/`fsync` inputs consumed by the renderers and the hsync/vsync/de sent to the display PHY.

---
 rtl/video_timing_gen.sv | 98 +++++++++
 tb/tb_video_timing_gen.sv | 119 +++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: signed pixel coordinates plus sync, data-enable and
// line/frame strobes, every output registered and aligned to the same cycle.
module video_timing_gen #(
    parameter int   HRES      = 640,
    parameter int   VRES      = 480,
    parameter int   HFP       = 16,
    parameter int   HSW       = 96,
    parameter int   HBP       = 48,
    parameter int   VFP       = 10,
    parameter int   VSW       = 2,
    parameter int   VBP       = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               lsync,
    output logic               fsync,
    output logic [7:0]         frame_cnt
);

    localparam int H_STA_I = -(HFP + HSW + HBP);
    localparam int V_STA_I = -(VFP + VSW + VBP);

    generate
        if (H_STA_I < -2048 || V_STA_I < -2048 || HRES > 2047 || VRES > 2047) begin : g_range_err
            $error("video_timing_gen: timing does not fit 12-bit signed coordinates");
        end
    endgenerate

    localparam logic signed [11:0] H_STA = 12'(H_STA_I);
    localparam logic signed [11:0] H_SYB = 12'(H_STA_I + HFP);
    localparam logic signed [11:0] H_SYE = 12'(H_STA_I + HFP + HSW - 1);
    localparam logic signed [11:0] H_END = 12'(HRES - 1);
    localparam logic signed [11:0] V_STA = 12'(V_STA_I);
    localparam logic signed [11:0] V_SYB = 12'(V_STA_I + VFP);
    localparam logic signed [11:0] V_SYE = 12'(V_STA_I + VFP + VSW - 1);
    localparam logic signed [11:0] V_END = 12'(VRES - 1);

    logic signed [11:0] hpos_d, hpos_q, vpos_d, vpos_q;
    logic               hsync_d, hsync_q, vsync_d, vsync_q;
    logic               de_d, de_q, lsync_d, lsync_q, fsync_d, fsync_q;
    logic [7:0]         frame_cnt_d, frame_cnt_q;

    // Flags are decoded from the next coordinates so they land in the same
    // cycle as the coordinates they describe.
    always_comb begin
        hpos_d = hpos_q + 12'sd1;
        vpos_d = vpos_q;
        if (hpos_q == H_END) begin
            hpos_d = H_STA;
            vpos_d = (vpos_q == V_END) ? V_STA : vpos_q + 12'sd1;
        end
        hsync_d     = (hpos_d >= H_SYB && hpos_d <= H_SYE) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d     = (vpos_d >= V_SYB && vpos_d <= V_SYE) ? VSYNC_POL : ~VSYNC_POL;
        de_d        = (hpos_d >= 12'sd0) && (vpos_d >= 12'sd0);
        lsync_d     = (hpos_d == H_STA);
        fsync_d     = (hpos_d == H_STA) && (vpos_d == V_STA);
        frame_cnt_d = frame_cnt_q + {7'd0, fsync_d};
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q      <= H_STA;
            vpos_q      <= V_STA;
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            de_q        <= 1'b0;
            lsync_q     <= 1'b0;
            fsync_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            hpos_q      <= hpos_d;
            vpos_q      <= vpos_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            lsync_q     <= lsync_d;
            fsync_q     <= fsync_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hpos      = hpos_q;
    assign vpos      = vpos_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign lsync     = lsync_q;
    assign fsync     = fsync_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster; expected outputs come from
// the cycle count since reset release (position within line and frame).
module tb_video_timing_gen;

    localparam int   HRES = 8, VRES = 6, HFP = 2, HSW = 3, HBP = 1;
    localparam int   VFP = 1, VSW = 2, VBP = 2;
    localparam logic HPOL = 1'b0, VPOL = 1'b1;
    localparam int   LINE  = HRES + HFP + HSW + HBP;
    localparam int   NL    = VRES + VFP + VSW + VBP;
    localparam int   FRAME = LINE * NL;

    logic               pixel_clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [11:0] hpos, vpos;
    logic               hsync, vsync, de, lsync, fsync;
    logic [7:0]         frame_cnt;

    int tests = 0, fails = 0;
    int t = 0;
    int since_fs = 0, since_ls = 0, de_acc = 0, vs_acc = 0, hs_acc = 0;
    bit have_fs = 0, have_ls = 0;

    video_timing_gen #(
        .HRES(HRES), .VRES(VRES), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VFP(VFP), .VSW(VSW), .VBP(VBP), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
        .hsync(hsync), .vsync(vsync), .de(de), .lsync(lsync), .fsync(fsync),
        .frame_cnt(frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, got, exp);
        end
    endtask

    // Expected outputs from elapsed cycles: t = 0 is the reset-state cycle.
    task automatic check_now(input bit agg);
        int ph, ln;
        ph = t % LINE;
        ln = (t / LINE) % NL;
        chk("hpos", $signed(hpos), -(HFP + HSW + HBP) + ph);
        chk("vpos", $signed(vpos), -(VFP + VSW + VBP) + ln);
        chk("hsync", {31'd0, hsync}, (ph >= HFP && ph < HFP + HSW) ? {31'd0, HPOL} : {31'd0, ~HPOL});
        chk("vsync", {31'd0, vsync}, (ln >= VFP && ln < VFP + VSW) ? {31'd0, VPOL} : {31'd0, ~VPOL});
        chk("de", {31'd0, de}, (ph >= HFP + HSW + HBP && ln >= VFP + VSW + VBP) ? 1 : 0);
        chk("lsync", {31'd0, lsync}, (t > 0 && ph == 0) ? 1 : 0);
        chk("fsync", {31'd0, fsync}, (t > 0 && t % FRAME == 0) ? 1 : 0);
        chk("frame_cnt", {24'd0, frame_cnt}, (t / FRAME) % 256);
        if (!agg) return;
        if (fsync === 1'b1) begin
            if (have_fs) begin
                chk("frame_period", since_fs, FRAME);
                chk("de_per_frame", de_acc, HRES * VRES);
                chk("vsync_per_frame", vs_acc, VSW * LINE);
            end
            have_fs = 1; since_fs = 0; de_acc = 0; vs_acc = 0;
        end
        if (lsync === 1'b1) begin
            if (have_ls) begin
                chk("line_period", since_ls, LINE);
                chk("hsync_per_line", hs_acc, HSW);
            end
            have_ls = 1; since_ls = 0; hs_acc = 0;
        end
        since_fs++; since_ls++;
        de_acc += int'(de === 1'b1);
        vs_acc += int'(vsync === VPOL);
        hs_acc += int'(hsync === HPOL);
    endtask

    task automatic step();
        @(posedge pixel_clk);
        if (rst_n) t++;
        @(negedge pixel_clk);
        check_now(1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset held for 4 clocks, then release between edges.
        rst_n = 1'b0;
        run(4);
        rst_n = 1'b1;
        step();
        chk("first_hpos", $signed(hpos), -(HFP + HSW + HBP) + 1);

        run(2 * FRAME + int'($urandom_range(0, FRAME)));

        // Asynchronous resets at random raster positions.
        for (int k = 0; k < 3; k++) begin
            run(int'($urandom_range(1, 2 * FRAME)));
            @(posedge pixel_clk);
            #2 rst_n = 1'b0;
            #1 t = 0;
            check_now(0);
            have_fs = 0; have_ls = 0;
            run(int'($urandom_range(1, 4)));
            rst_n = 1'b1;
            run(FRAME + int'($urandom_range(0, LINE)));
        end

        // Long run through the 8-bit frame counter wrap.
        run(257 * FRAME + int'($urandom_range(0, FRAME)));
        chk("wrapped_frames", {31'd0, (t >= 256 * FRAME) ? 1'b1 : 1'b0}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
